// File: rtl/lsu_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM state encodings.
package lsu_defs;

    localparam int unsigned XLEN = 32;

    typedef logic [2:0] funct3_t;

    localparam funct3_t F3_B  = 3'b000;
    localparam funct3_t F3_H  = 3'b001;
    localparam funct3_t F3_W  = 3'b010;
    localparam funct3_t F3_BU = 3'b100;
    localparam funct3_t F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/lsu_unit_if.sv
// Simple req/ack data-bus between the load/store unit (master) and memory (slave).
interface lsu_unit_if;
    import lsu_defs::*;

    logic            bus_req;
    logic            bus_we;
    logic [XLEN-1:0] bus_addr;
    logic [3:0]      bus_be;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_ack;
    logic [XLEN-1:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );

endinterface

// File: rtl/lsu_unit_align.sv
// Combinational lane logic: byte enables, store steering, load extraction and
// the misaligned/illegal-access flag.
module lsu_align
    import lsu_defs::*;
(
    input  funct3_t     funct3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] bus_rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] ld_data,
    output logic        misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_v = bus_rdata[7:0];
            2'd1:    byte_v = bus_rdata[15:8];
            2'd2:    byte_v = bus_rdata[23:16];
            default: byte_v = bus_rdata[31:24];
        endcase
        half_v = addr_lo[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    end

    always_comb begin
        be          = 4'b0000;
        wdata_lanes = wdata;
        ld_data     = bus_rdata;
        misaligned  = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                ld_data     = (funct3 == F3_B) ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
                misaligned  = we && (funct3 == F3_BU);
            end
            F3_H, F3_HU: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                ld_data     = (funct3 == F3_H) ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
                misaligned  = addr_lo[0] || (we && (funct3 == F3_HU));
            end
            F3_W: begin
                be         = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Memory-stage load/store unit: one byte/half/word access per start over a req/ack bus,
// with misalignment rejection and an ack timeout.
module lsu_unit
    import lsu_defs::*;
#(
    parameter int unsigned V       = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         mem_write,
    input  logic [2:0]   funct3,
    input  logic [V-1:0] addr,
    input  logic [V-1:0] wdata,
    output logic         stall,
    output logic         done,
    output logic [V-1:0] rdata,
    output logic         misaligned,
    output logic         bus_err,
    lsu_unit_if.master   bus
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    funct3_t       f3_q, f3_d;
    logic [V-1:0]  addr_q, addr_d;
    logic [V-1:0]  wdata_q, wdata_d;
    logic [V-1:0]  rdata_q, rdata_d;
    logic          mis_q, mis_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic          in_idle, in_access;
    funct3_t       al_f3;
    logic [1:0]    al_lo;
    logic          al_we;
    logic [3:0]    al_be;
    logic [V-1:0]  al_lanes;
    logic [V-1:0]  al_ld;
    logic          al_mis;

    assign in_idle   = (state_q == ST_IDLE);
    assign in_access = (state_q == ST_ACCESS);

    // In IDLE the aligner judges the incoming request; afterwards it works on the captured one.
    assign al_f3 = in_idle ? funct3    : f3_q;
    assign al_lo = in_idle ? addr[1:0] : addr_q[1:0];
    assign al_we = in_idle ? mem_write : we_q;

    lsu_align u_align (
        .funct3      (al_f3),
        .addr_lo     (al_lo),
        .we          (al_we),
        .wdata       (wdata_q),
        .bus_rdata   (bus.bus_rdata),
        .be          (al_be),
        .wdata_lanes (al_lanes),
        .ld_data     (al_ld),
        .misaligned  (al_mis)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        mis_d   = mis_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    we_d    = mem_write;
                    f3_d    = funct3;
                    addr_d  = addr;
                    wdata_d = wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    mis_d   = al_mis;
                    cnt_d   = '0;
                    state_d = al_mis ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ack takes priority over an expiring counter.
                if (bus.bus_ack) begin
                    rdata_d = we_q ? '0 : al_ld;
                    state_d = ST_DONE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= F3_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stall      = (in_idle && start) || in_access;
    assign done       = (state_q == ST_DONE);
    assign rdata      = rdata_q;
    assign misaligned = mis_q;
    assign bus_err    = err_q;

    assign bus.bus_req   = in_access;
    assign bus.bus_we    = in_access && we_q;
    assign bus.bus_addr  = in_access ? {addr_q[V-1:2], 2'b00} : '0;
    assign bus.bus_be    = in_access ? al_be : 4'b0000;
    assign bus.bus_wdata = in_access ? al_lanes : '0;

endmodule

// File: tb/tb_lsu_unit.sv
// Randomized self-checking bench for lsu_unit against a byte-arithmetic reference model.
module tb_lsu_unit;

    localparam int TB_TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic        bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic        hold_ok;
    logic [31:0] hold_rdata;

    lsu_unit_if bus_if ();

    lsu_unit #(
        .V       (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .bus        (bus_if.master)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Reference: access size is 1 << funct3[1:0] bytes; lanes and extraction by byte offset.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, input logic [31:0] rw,
                                  output logic mis, output logic [3:0] be,
                                  output logic [31:0] lanes, output logic [31:0] ld);
        int          nb;
        int          off;
        int          be_i;
        logic [31:0] mask;
        logic [31:0] v;
        off  = int'(a & 32'd3);
        nb   = 1 << f3[1:0];
        mis  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3[2]) || (off % nb != 0);
        be_i = ((1 << nb) - 1) << off;
        be   = be_i[3:0];
        for (int i = 0; i < 4; i++) lanes[8*i +: 8] = wd[8*(i % nb) +: 8];
        mask = (nb >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nb)) - 32'h1);
        v    = (rw >> (8 * off)) & mask;
        if (!f3[2] && nb < 4 && v[8*nb-1]) v = v | ~mask;
        ld = v;
    endfunction

    // ack_at: ACCESS cycle (1-based) in which bus_ack is pulsed; 0 = never.
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rw, input int ack_at);
        logic        e_mis, e_err;
        logic [3:0]  e_be;
        logic [31:0] e_lanes, e_ld, e_rdata;
        int          done_at;
        model(we, f3, a, wd, rw, e_mis, e_be, e_lanes, e_ld);
        if (e_mis) done_at = 1;
        else if (ack_at >= 1 && ack_at <= TB_TIMEOUT) done_at = ack_at + 1;
        else done_at = TB_TIMEOUT + 1;
        e_err   = !e_mis && (done_at == TB_TIMEOUT + 1) && (ack_at != TB_TIMEOUT);
        e_rdata = e_err ? 32'd0 : e_ld;

        @(posedge clk); #1;
        start = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd; bus_if.bus_ack = 1'b0;
        #1;
        check_val("stall_accept", 32'(stall), 32'd1);
        check_val("done_accept", 32'(done), 32'd0);
        if (hold_ok) check_val("rdata_hold", rdata, hold_rdata);

        for (int j = 1; j <= done_at; j++) begin
            @(posedge clk); #1;
            start     = 1'b0;
            mem_write = 1'($urandom);
            funct3    = 3'($urandom);
            addr      = $urandom;
            wdata     = $urandom;
            bus_if.bus_ack   = (j == ack_at);
            bus_if.bus_rdata = (j == ack_at) ? rw : $urandom;
            #1;
            if (j < done_at) begin
                check_val("req_access", 32'(bus_if.bus_req), 32'd1);
                check_val("stall_access", 32'(stall), 32'd1);
                check_val("done_access", 32'(done), 32'd0);
                check_val("bus_addr", bus_if.bus_addr, a & ~32'd3);
                check_val("bus_be", 32'(bus_if.bus_be), 32'(e_be));
                check_val("bus_we", 32'(bus_if.bus_we), 32'(we));
                if (we) check_val("bus_wdata", bus_if.bus_wdata, e_lanes);
            end else begin
                check_val("done_pulse", 32'(done), 32'd1);
                check_val("stall_done", 32'(stall), 32'd0);
                check_val("req_done", 32'(bus_if.bus_req), 32'd0);
                check_val("misaligned", 32'(misaligned), 32'(e_mis));
                check_val("bus_err", 32'(bus_err), 32'(e_err));
                if (e_err || (!we && !e_mis)) check_val("rdata", rdata, e_rdata);
            end
        end
        hold_ok    = e_err || (!we && !e_mis);
        hold_rdata = e_rdata;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_stall"}, 32'(stall), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_rdata"}, rdata, 32'd0);
        check_val({tag, "_mis"}, 32'(misaligned), 32'd0);
        check_val({tag, "_err"}, 32'(bus_err), 32'd0);
        check_val({tag, "_req"}, 32'(bus_if.bus_req), 32'd0);
        check_val({tag, "_we"}, 32'(bus_if.bus_we), 32'd0);
        check_val({tag, "_addr"}, bus_if.bus_addr, 32'd0);
        check_val({tag, "_be"}, 32'(bus_if.bus_be), 32'd0);
        check_val({tag, "_wdata"}, bus_if.bus_wdata, 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mem_write = 1'b0; funct3 = 3'd0;
        addr = 32'd0; wdata = 32'd0;
        bus_if.bus_ack = 1'b0; bus_if.bus_rdata = 32'd0;
        hold_ok = 1'b1; hold_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Directed cases
        run_op(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1);
        run_op(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 2);
        run_op(1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1);
        run_op(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 1);
        run_op(1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 1);
        run_op(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678, 0);
        run_op(1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1234_5678, TB_TIMEOUT);
        run_op(1'b1, 3'b101, 32'h0000_0010, 32'h0, 32'h0, 1);
        run_op(1'b0, 3'b111, 32'h0000_0010, 32'h0, 32'h0, 1);

        // Back-to-back lw then sw with start held high
        @(posedge clk); #1;
        start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
        #1; check_val("b2b_stall_c0", 32'(stall), 32'd1);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
        #1; check_val("b2b_stall_c1", 32'(stall), 32'd1);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0; mem_write = 1'b1; addr = 32'h0000_0304; wdata = 32'h1357_9BDF;
        #1;
        check_val("b2b_done1", 32'(done), 32'd1);
        check_val("b2b_stall_d1", 32'(stall), 32'd0);
        check_val("b2b_rdata1", rdata, 32'hCAFE_F00D);
        @(posedge clk); #1; #1;
        check_val("b2b_stall_c3", 32'(stall), 32'd1);
        check_val("b2b_done_c3", 32'(done), 32'd0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b1;
        #1;
        check_val("b2b_we", 32'(bus_if.bus_we), 32'd1);
        check_val("b2b_addr", bus_if.bus_addr, 32'h0000_0304);
        check_val("b2b_wdata", bus_if.bus_wdata, 32'h1357_9BDF);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0; start = 1'b0;
        #1;
        check_val("b2b_done2", 32'(done), 32'd1);
        check_val("b2b_stall_d2", 32'(stall), 32'd0);
        hold_ok = 1'b0;

        // Randomized accesses
        for (int n = 0; n < 80; n++) begin
            run_op(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(0, TB_TIMEOUT + 1)));
        end

        // Reset in the third ACCESS cycle, then a late ack
        @(posedge clk); #1;
        start = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h0000_0400;
        bus_if.bus_ack = 1'b0;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #1; check_val("rst_mid_req", 32'(bus_if.bus_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1; check_all_zero("rst_mid");
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
        #1; check_val("late_ack_done0", 32'(done), 32'd0);
        @(posedge clk); #1;
        bus_if.bus_ack = 1'b0;
        #1;
        check_val("late_ack_done1", 32'(done), 32'd0);
        check_val("late_ack_req", 32'(bus_if.bus_req), 32'd0);
        hold_ok = 1'b1; hold_rdata = 32'd0;
        run_op(1'b0, 3'b101, 32'h0000_0502, 32'h0, 32'h8001_7FFF, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_unit.md
# lsu_unit

Load/store unit for the memory stage of the RISC-V core, directly downstream of the execute-stage ALU. It takes the ALU result as the effective address, performs one byte/half/word access over a simple req/ack data-bus handshake, and returns sign- or zero-extended load data for writeback. The unit stalls the pipeline while an access is in flight and reports misaligned or timed-out accesses instead of issuing them.

## Interface
- V, 32: data/address width; only 32 is supported.
- TIMEOUT, 255: maximum ACCESS cycles without `bus_ack` before `bus_err`.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  memory op present in stage; sampled only in IDLE
- mem_write  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width/sign code
- addr  in  V  effective address (ALU result)
- wdata  in  V  store data (rs2)
- stall  out  1  hold the pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  V  extended load data; valid with `done`
- misaligned  out  1  valid with `done`
- bus_err  out  1  timeout flag; valid with `done`
- bus_req  out  1  bus request; held until ack
- bus_we  out  1  write enable
- bus_addr  out  V  word address, {addr[V-1:2], 2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  V  lane-steered store data
- bus_ack  in  1  bus completion; single cycle
- bus_rdata  in  V  read word; valid with `bus_ack`

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE, start=1:
  - Capture mem_write, funct3, addr, and wdata into registers.
  - Go to DONE with misaligned=1 and no bus activity if the access is misaligned or funct3 is illegal. Misaligned means half with addr[0]=1, or word with addr[1:0]≠0. Illegal codes are 011, 110, 111, and 100/101 on a store.
  - Otherwise go to ACCESS.
- ACCESS:
  - Drive bus_req=1 with stable bus_addr, bus_we, bus_be, and bus_wdata.
  - On bus_ack, capture load data and go to DONE.
  - A cycle counter increments each ACCESS cycle without ack. When it reaches TIMEOUT-1 without ack, go to DONE with bus_err=1 and rdata=0.
  - If ack arrives in the same cycle the counter expires, the ack wins.
- DONE: done=1 for one cycle, then return to IDLE. The flags and rdata hold until the next start.
- Byte enables:
  - Byte access: be = 4'b0001 << addr[1:0].
  - Half access: 0011 or 1100, selected by addr[1].
  - Word access: 1111.
- Store lanes:
  - sb: {4{wdata[7:0]}}
  - sh: {2{wdata[15:0]}}
  - sw: wdata
- Load extraction:
  - Select the byte or half by addr[1:0].
  - lb/lh sign-extend from bit 7/15.
  - lbu/lhu zero-extend.
  - lw passes the word through.
- stall = (state==IDLE & start) | (state==ACCESS). stall is low in DONE so the pipeline advances on the DONE edge.

## Timing
- Reset values: state IDLE, counter 0, and every output 0 (stall, done, rdata, misaligned, bus_err, bus_req, bus_we, bus_addr, bus_be, bus_wdata).
- Cycle numbering for a bus access:
  - Cycle 0: start is accepted.
  - Cycle 1: bus_req rises.
  - Cycle k≥1: ack is seen.
  - Cycle k+1: done=1.
  - Minimum latency is 2 cycles.
- Misaligned or illegal access: done in cycle 1; bus_req never asserts.
- Timeout: done in cycle TIMEOUT+1.
- bus_req drops on the edge that captures bus_ack.
- A new start may arrive in the cycle after DONE.
- Reset mid-access: the next reset edge forces IDLE and bus_req=0. Any later ack is ignored.
- A bus_ack seen in IDLE or DONE is ignored.

## Structure
- Shared package `lsu_defs`:
  - funct3 codes: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - FSM state encodings.
- Sub-module `lsu_align`: purely combinational. It derives be, steered store data, extended load data, and the misaligned/illegal flag from funct3, addr[1:0], wdata, and bus_rdata.

## Test plan
- sw 0xDEADBEEF to 0x100, ack in cycle 1 -> bus_addr=0x100, be=1111, done in cycle 2, no flags.
- lb from 0x103 with bus_rdata=0x80FFFFFF -> be=1000, rdata=0xFFFFFF80. lbu from the same address -> rdata=0x00000080.
- sh 0x1234 to 0x102 -> bus_wdata=0x12341234, be=1100. lh from 0x101 -> misaligned=1, done in cycle 1, bus_req stays 0.
- Load with ack withheld, TIMEOUT=4 -> bus_req high for 4 cycles, done with bus_err=1 and rdata=0. Repeat with ack in the 4th ACCESS cycle -> bus_err=0.
- Reset asserted in the 3rd ACCESS cycle -> next cycle state IDLE and all outputs 0. A late ack produces no done.
- Back-to-back lw, sw with start held -> two complete accesses, and stall low only in each DONE cycle.
